// File: rtl/bus_dma_master.sv
// Word-copy DMA master: CPU-programmed SRC/DST/LEN, copies LEN words as read/write beat pairs
// over the valid/ready memory bus once the arbiter grants it.
module bus_dma_master #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        regCS_i,
    input  logic [1:0]  regAddr_i,
    input  logic        regWrite_i,
    input  logic [31:0] regDataIn_i,
    output logic [31:0] regDataOut_o,
    output logic        busRequest_o,
    input  logic        busGrant_i,
    output logic [31:0] mAddress_o,
    output logic [31:0] mDataOut_o,
    input  logic [31:0] mDataIn_i,
    output logic        mValid_o,
    output logic        mInstr_o,
    output logic        mWriteEnable_o,
    input  logic        mReady_i,
    output logic        irq_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_GAP, S_WR_REQ, S_WR_GAP, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 done_q, done_d, aborted_q, aborted_d;
    logic                 abort_q, abort_d, irq_en_q, irq_en_d;
    logic                 issued_q, issued_d;
    logic                 busy, reg_wr, req_state;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign reg_wr    = regCS_i & regWrite_i;
    assign req_state = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);

    // Once a beat is issued it is held even if the grant misbehaves.
    assign mValid_o       = req_state && (busGrant_i || issued_q);
    assign mWriteEnable_o = (state_q == S_WR_REQ);
    assign mAddress_o     = (state_q == S_RD_REQ) ? src_q :
                            (state_q == S_WR_REQ) ? dst_q : 32'd0;
    assign mDataOut_o     = buf_q;
    assign mInstr_o       = 1'b0;
    assign busRequest_o   = busy;
    assign irq_o          = done_q & irq_en_q;

    always_comb begin
        regDataOut_o = 32'd0;
        case (regAddr_i)
            2'd0:    regDataOut_o = src_q;
            2'd1:    regDataOut_o = dst_q;
            2'd2:    regDataOut_o = {{(32-LEN_WIDTH){1'b0}}, len_q};
            default: regDataOut_o = {28'd0, irq_en_q, aborted_q, done_q, busy};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        buf_d     = buf_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        abort_d   = abort_q;
        irq_en_d  = irq_en_q;
        issued_d  = mValid_o & ~mReady_i;

        if (reg_wr && !busy) begin
            case (regAddr_i)
                2'd0:    src_d = {regDataIn_i[31:2], 2'b00};
                2'd1:    dst_d = {regDataIn_i[31:2], 2'b00};
                2'd2:    len_d = regDataIn_i[LEN_WIDTH-1:0];
                default: ;
            endcase
        end

        if (reg_wr && regAddr_i == 2'd3) begin
            irq_en_d = regDataIn_i[3];
            if (busy) begin
                if (regDataIn_i[1]) abort_d = 1'b1;
            end else if (regDataIn_i[0]) begin
                // Start wins over clear-done; an empty transfer completes without touching the bus.
                aborted_d = 1'b0;
                abort_d   = 1'b0;
                done_d    = (len_q == '0);
                state_d   = (len_q == '0) ? S_DONE : S_RD_REQ;
            end else if (regDataIn_i[2]) begin
                done_d    = 1'b0;
                aborted_d = 1'b0;
                state_d   = S_IDLE;
            end
        end

        case (state_q)
            S_RD_REQ: if (mValid_o && mReady_i) begin
                buf_d   = mDataIn_i;
                state_d = S_RD_GAP;
            end
            S_RD_GAP: if (!mReady_i) state_d = S_WR_REQ;
            S_WR_REQ: if (mValid_o && mReady_i) begin
                src_d   = src_q + 32'd4;
                dst_d   = dst_q + 32'd4;
                len_d   = len_q - LEN_WIDTH'(1);
                state_d = S_WR_GAP;
            end
            S_WR_GAP: if (!mReady_i) begin
                if (len_q == '0 || abort_d) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    aborted_d = abort_d;
                    abort_d   = 1'b0;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= '0;
            buf_q     <= 32'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            issued_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            buf_q     <= buf_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            abort_q   <= abort_d;
            irq_en_q  <= irq_en_d;
            issued_q  <= issued_d;
        end
    end
endmodule
